// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared state type and constants for the binary-to-BCD converter
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_INC    = 4'd3;

  // Sized for the 32-bit MIPS word: 2^32-1 has ten decimal digits.
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DIGITS = 10;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// rtl/bin_to_bcd_seq_bcd_add3.sv - combinational double-dabble digit correction (>=5 gets +3)
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + ADD3_INC : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
// Optional signed input handling is enabled by defining BIN_TO_BCD_SIGNED_EN.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]     out_ndigits,
  output logic                            out_negative
);

  localparam int ACC_W  = BCD_DIGIT_W * DIGITS;
  localparam int ND_W   = $clog2(DIGITS + 1);
  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  state_t              r_state;
  logic [ITER_W-1:0]   r_iter;
  logic [ACC_W-1:0]    r_acc;
  logic [WIDTH-1:0]    r_sr;
  logic                r_out_valid;
  logic [ACC_W-1:0]    r_out_bcd;
  logic [ND_W-1:0]     r_out_ndigits;

  logic [ACC_W-1:0]       w_adj;
  logic [ACC_W+WIDTH-1:0] w_shift;
  logic [ACC_W-1:0]       w_next_acc;
  logic [WIDTH-1:0]       w_load;
  logic [ND_W-1:0]        w_ndigits;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The top accumulator bit falls off here; it is always 0 when DIGITS is large enough.
  assign w_shift    = {w_adj, r_sr} << 1;
  assign w_next_acc = w_shift[ACC_W+WIDTH-1:WIDTH];

  always_comb begin
    w_ndigits = ND_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (w_next_acc[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) w_ndigits = ND_W'(i + 1);
    end
  end

`ifdef BIN_TO_BCD_SIGNED_EN
  logic r_neg_pend;
  logic r_out_negative;

  // Two's-complement negate; -2^(WIDTH-1) wraps to 2^(WIDTH-1), read back as unsigned.
  assign w_load       = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
  assign out_negative = r_out_negative;
`else
  assign w_load       = in_data;
  assign out_negative = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_iter        <= '0;
      r_acc         <= '0;
      r_sr          <= '0;
      r_out_valid   <= 1'b0;
      r_out_bcd     <= '0;
      r_out_ndigits <= ND_W'(1);
`ifdef BIN_TO_BCD_SIGNED_EN
      r_neg_pend     <= 1'b0;
      r_out_negative <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sr    <= w_load;
            r_acc   <= '0;
            r_iter  <= '0;
            r_state <= SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
            r_neg_pend <= in_data[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_acc  <= w_next_acc;
          r_sr   <= w_shift[WIDTH-1:0];
          r_iter <= r_iter + ITER_W'(1);
          if (r_iter == LAST_ITER) begin
            r_out_bcd     <= w_next_acc;
            r_out_ndigits <= w_ndigits;
            r_out_valid   <= 1'b1;
            r_state       <= DONE;
`ifdef BIN_TO_BCD_SIGNED_EN
            r_out_negative <= r_neg_pend;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign out_bcd     = r_out_bcd;
  assign out_ndigits = r_out_ndigits;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - randomized self-checking bench for bin_to_bcd_seq (honours BIN_TO_BCD_SIGNED_EN)
module tb_bin_to_bcd_seq;

  localparam int W   = 32;
  localparam int D   = 10;
  localparam int NDW = $clog2(D + 1);

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [4*D-1:0] out_bcd;
  logic [NDW-1:0] out_ndigits;
  logic           out_negative;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [4*D-1:0] bcd;
    int             nd;
    logic           neg;
    int             acc;
  } exp_t;

  exp_t q[$];
  exp_t e_new;
  bit   seen = 1'b0;
  bit   tput = 1'b0;
  bit   have_last = 1'b0;
  int   last_acc = 0;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_ndigits  (out_ndigits),
    .out_negative (out_negative)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic longint unsigned magnitude(input logic [W-1:0] v);
`ifdef BIN_TO_BCD_SIGNED_EN
    if (v[W-1]) return (64'd1 << W) - 64'(v);
`endif
    return 64'(v);
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input longint unsigned v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int ndig(input longint unsigned v);
    int n = 0;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return (n == 0) ? 1 : n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard: sample at negedge, so values seen here are what the next posedge will act on.
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("out_bcd", 64'(out_bcd), 64'(q[0].bcd));
          chk("out_ndigits", 64'(out_ndigits), 64'(q[0].nd));
          chk("out_negative", 64'(out_negative), 64'(q[0].neg));
          chk("in_ready_in_done", 64'(in_ready), 64'd0);
          if (!seen) chk("latency", 64'(cyc - q[0].acc), 64'(W));
          seen = 1'b1;
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        chk("in_ready_idle_vs_busy", 64'(in_ready), (q.size() == 0) ? 64'd1 : 64'd0);
      end
      if (in_valid && in_ready) begin
        e_new.bcd = to_bcd(magnitude(in_data));
        e_new.nd  = ndig(magnitude(in_data));
`ifdef BIN_TO_BCD_SIGNED_EN
        e_new.neg = in_data[W-1];
`else
        e_new.neg = 1'b0;
`endif
        e_new.acc = cyc + 1;
        if (tput && have_last) chk("throughput", 64'(cyc + 1 - last_acc), 64'(W + 2));
        last_acc  = cyc + 1;
        have_last = 1'b1;
        q.push_back(e_new);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_conv(input logic [W-1:0] v);
    int t = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    chk("start_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < W + 10) begin
      step();
      t++;
    end
    chk("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_release", 64'(in_ready), 64'd1);
  endtask

  task automatic conv_lit(input logic [W-1:0] v, input logic [4*D-1:0] xb, input int xn,
                          input logic xneg, input int hold);
    start_conv(v);
    wait_valid();
    repeat (hold) step();
    chk("lit_bcd", 64'(out_bcd), 64'(xb));
    chk("lit_ndigits", 64'(out_ndigits), 64'(xn));
    chk("lit_negative", 64'(out_negative), 64'(xneg));
    release_out();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_bcd"}, 64'(out_bcd), 64'd0);
    chk({tag, "_out_ndigits"}, 64'(out_ndigits), 64'd1);
    chk({tag, "_out_negative"}, 64'(out_negative), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    chk("model_bcd_255", 64'(to_bcd(64'd255)), 64'h255);
    chk("model_bcd_max", 64'(to_bcd(64'hFFFF_FFFF)), 64'h42_9496_7295);
    chk("model_nd_0", 64'(ndig(64'd0)), 64'd1);
    chk("model_nd_255", 64'(ndig(64'd255)), 64'd3);
    chk("model_nd_max", 64'(ndig(64'hFFFF_FFFF)), 64'd10);

    repeat (3) step();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    step();

    conv_lit(32'd0, 40'h0, 1, 1'b0, 0);
    conv_lit(32'd255, 40'h255, 3, 1'b0, 0);
`ifdef BIN_TO_BCD_SIGNED_EN
    conv_lit(32'hFFFF_FFFF, 40'h1, 1, 1'b1, 0);
    conv_lit(32'h8000_0000, 40'h21_4748_3648, 10, 1'b1, 0);
`else
    conv_lit(32'hFFFF_FFFF, 40'h42_9496_7295, 10, 1'b0, 0);
`endif

    conv_lit(32'd4321, 40'h4321, 4, 1'b0, 20);
    conv_lit(32'd1000, 40'h1000, 4, 1'b0, 0);

    // Abort a conversion of 12345 right after its tenth iteration.
    start_conv(32'd12345);
    repeat (10) step();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_shift_reset");
    step();
    step();
    reset_n = 1'b1;
    step();
    conv_lit(32'd9, 40'h9, 1, 1'b0, 0);

    start_conv(32'd77);
    wait_valid();
    step();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_done_reset");
    step();
    reset_n = 1'b1;
    step();

    tput      = 1'b1;
    have_last = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (4 * (W + 2)) begin
      in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    tput     = 1'b0;
    repeat (W + 4) step();

    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       in_data = '0;
        1:       in_data = '1;
        default: in_data = $urandom >> $urandom_range(0, 31);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 5) step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
